sisc_ctrl_seq: RTL

- Multi-cycle control sequencer for the SISC datapath.
- Decodes opcode, mode and status fields and steps each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK.
- Drives every datapath select and enable: register-read address mux select (rd_sel), ALU op, PC update, register-file and data-memory writes.
- Sits between the instruction register and the datapath muxes, register file, ALU and memories.

---
 rtl/sisc_ctrl_seq_pkg.sv | 44 ++++
 rtl/sisc_br_eval.sv | 27 ++
 rtl/sisc_ctrl_seq.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/sisc_ctrl_seq_pkg.sv
// Shared definitions for the SISC control sequencer: opcodes, state encoding,
// datapath select encodings and the default start-up delay.
package sisc_ctrl_seq_pkg;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_ALU = 4'b0001;
  localparam logic [3:0] OP_BRA = 4'b0010;
  localparam logic [3:0] OP_BRR = 4'b0011;
  localparam logic [3:0] OP_BNE = 4'b0100;
  localparam logic [3:0] OP_BNR = 4'b0101;
  localparam logic [3:0] OP_LOD = 4'b1000;
  localparam logic [3:0] OP_STR = 4'b1001;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic [2:0] {
    S_START,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WRITEBACK,
    S_HALT
  } state_t;

  localparam logic [1:0] RD_RD = 2'd0;
  localparam logic [1:0] RD_RT = 2'd1;
  localparam logic [1:0] RD_RS = 2'd2;

  localparam logic [1:0] ALU_FN   = 2'b00;
  localparam logic [1:0] ALU_ADDR = 2'b01;
  localparam logic [1:0] ALU_PASS = 2'b10;

  localparam int START_CYC_DEF = 2;

  // Port-B read address select used while an instruction's operands are live.
  function automatic logic [1:0] rd_sel_for(input logic [3:0] op);
    case (op)
      OP_ALU:  return RD_RT;
      OP_LOD:  return RD_RS;
      default: return RD_RD;
    endcase
  endfunction

endpackage

// File: rtl/sisc_br_eval.sv
// Combinational branch-taken evaluation from opcode, condition mask and status.
module sisc_br_eval
  import sisc_ctrl_seq_pkg::*;
#(
  parameter int OPW = 4,
  parameter int STW = 4
) (
  input  logic [OPW-1:0] i_opcode,
  input  logic [OPW-1:0] i_mm,
  input  logic [STW-1:0] i_stat,
  output logic           o_taken
);

  logic w_hit;

  // An all-zero mask never hits, so BRA/BRR never take and BNE/BNR always take.
  always_comb begin
    w_hit   = |(i_stat & i_mm);
    o_taken = 1'b0;
    case (i_opcode)
      OP_BRA, OP_BRR: o_taken = w_hit;
      OP_BNE, OP_BNR: o_taken = ~w_hit;
      default:        o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/sisc_ctrl_seq.sv
// Multi-cycle SISC control sequencer (START/FETCH/DECODE/EXECUTE/MEM/WRITEBACK/HALT).
// Optional SISC_CTRL_RETIRE_CNT_EN adds a 16-bit retired-instruction counter.
module sisc_ctrl_seq
  import sisc_ctrl_seq_pkg::*;
#(
  parameter int OPW       = 4,
  parameter int STW       = 4,
  parameter int START_CYC = START_CYC_DEF
) (
  input  logic           clk,
  input  logic           rst_f,
  input  logic [OPW-1:0] opcode,
  input  logic [OPW-1:0] mm,
  input  logic [STW-1:0] stat,
  output logic           ir_load,
  output logic           pc_write,
  output logic           pc_sel,
  output logic           br_sel,
  output logic [1:0]     rd_sel,
  output logic [1:0]     alu_op,
  output logic           stat_en,
  output logic           rf_we,
  output logic           wb_sel,
  output logic           dm_we,
  output logic           halted
`ifdef SISC_CTRL_RETIRE_CNT_EN
  ,
  output logic [15:0]    retire_cnt
`endif
);

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_cnt;
  logic       w_taken;

  sisc_br_eval #(
    .OPW (OPW),
    .STW (STW)
  ) u_br_eval (
    .i_opcode (opcode),
    .i_mm     (mm),
    .i_stat   (stat),
    .o_taken  (w_taken)
  );

  always_ff @(posedge clk) begin
    if (!rst_f) begin
      r_state <= S_START;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_next;
      if (r_state == S_START) r_cnt <= r_cnt + 2'd1;
    end
  end

  // Everything is gated by rst_f so a reset landing mid-instruction cannot write.
  always_comb begin
    w_next   = r_state;
    ir_load  = 1'b0;
    pc_write = 1'b0;
    pc_sel   = 1'b0;
    br_sel   = 1'b0;
    rd_sel   = RD_RD;
    alu_op   = ALU_FN;
    stat_en  = 1'b0;
    rf_we    = 1'b0;
    wb_sel   = 1'b0;
    dm_we    = 1'b0;
    halted   = 1'b0;
    if (rst_f) begin
      case (r_state)
        S_START: begin
          if (r_cnt == 2'(START_CYC - 1)) w_next = S_FETCH;
        end
        S_FETCH: begin
          ir_load  = 1'b1;
          pc_write = 1'b1;
          pc_sel   = 1'b0;
          w_next   = S_DECODE;
        end
        S_DECODE: begin
          rd_sel = rd_sel_for(opcode);
          case (opcode)
            OP_HLT:                         w_next = S_HALT;
            OP_ALU, OP_LOD, OP_STR,
            OP_BRA, OP_BRR, OP_BNE, OP_BNR: w_next = S_EXECUTE;
            default:                        w_next = S_FETCH;
          endcase
        end
        S_EXECUTE: begin
          w_next = S_FETCH;
          case (opcode)
            OP_ALU: begin
              alu_op  = ALU_FN;
              rd_sel  = RD_RT;
              stat_en = 1'b1;
              w_next  = S_WRITEBACK;
            end
            OP_LOD, OP_STR: begin
              alu_op = ALU_ADDR;
              rd_sel = rd_sel_for(opcode);
              w_next = S_MEM;
            end
            OP_BRA, OP_BNE, OP_BRR, OP_BNR: begin
              br_sel   = (opcode == OP_BRR) || (opcode == OP_BNR);
              pc_write = w_taken;
              pc_sel   = w_taken;
            end
            default: w_next = S_FETCH;
          endcase
        end
        S_MEM: begin
          if (opcode == OP_STR) begin
            dm_we  = 1'b1;
            rd_sel = RD_RD;
            w_next = S_FETCH;
          end else begin
            w_next = S_WRITEBACK;
          end
        end
        S_WRITEBACK: begin
          rf_we  = 1'b1;
          wb_sel = (opcode == OP_LOD);
          w_next = S_FETCH;
        end
        S_HALT: begin
          halted = 1'b1;
        end
        default: w_next = S_START;
      endcase
    end
  end

`ifdef SISC_CTRL_RETIRE_CNT_EN
  logic [15:0] r_retire_cnt;
  logic        w_retire;

  // Only completions count; the START->FETCH entry after reset does not.
  assign w_retire = rst_f && (w_next == S_FETCH) &&
                    ((r_state == S_DECODE) || (r_state == S_EXECUTE) ||
                     (r_state == S_MEM)    || (r_state == S_WRITEBACK));

  always_ff @(posedge clk) begin
    if (!rst_f)        r_retire_cnt <= 16'd0;
    else if (w_retire) r_retire_cnt <= r_retire_cnt + 16'd1;
  end

  assign retire_cnt = r_retire_cnt;
`endif

endmodule
